// File: rtl/imem_responder.sv
// Instruction-memory responder: sequential loader fills a word store, then fetches are served with 1-cycle latency.
// Optional misaligned-fetch checking is enabled by defining IMEM_ALIGN_CHK_EN.
module imem_responder #(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   input  logic              load_restart,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [31:0]       fetch_instr,
   output logic              fetch_fault
);

   localparam int                DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   CNT_MAX = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   CNT_ONE = 1;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;

   typedef enum logic {LOAD, RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       mem [DEPTH];

   logic              accept;
   logic              do_write;
   logic              out_of_range;
   logic [ADDR_W-1:0] word_idx;
   logic              misaligned;

   assign accept       = (state == RUN) && fetch_req;
   assign do_write     = (state == LOAD) && load_en;
   assign out_of_range = |fetch_addr[31:ADDR_W+2];
   assign word_idx     = fetch_addr[ADDR_W+1:2];
   assign load_done    = (state == RUN);
   assign fetch_ready  = (state == RUN);

`ifdef IMEM_ALIGN_CHK_EN
   assign misaligned = |fetch_addr[1:0];
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^fetch_addr[1:0];
   assign misaligned      = 1'b0;
`endif

   // NOTE: the store has no reset; its contents survive reset and reload so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_write) mem[ptr] <= load_data;
   end

   // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= LOAD;
         ptr        <= '0;
         load_count <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (load_en) begin
                  ptr <= ptr + PTR_ONE;
                  if (load_count != CNT_MAX) load_count <= load_count + CNT_ONE;
                  // Filling the last slot ends loading even without load_last.
                  if (load_last || (ptr == '1)) state <= RUN;
               end
            end
            RUN: begin
               if (load_restart) begin
                  state      <= LOAD;
                  ptr        <= '0;
                  load_count <= '0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // Response register; an accept in the same cycle as load_restart still completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_valid <= 1'b0;
         fetch_instr <= NOP_INSTR;
      end else begin
         fetch_valid <= accept;
         if (accept) begin
            if (out_of_range || misaligned) fetch_instr <= NOP_INSTR;
            else                             fetch_instr <= mem[word_idx];
         end
      end
   end

`ifdef IMEM_ALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fetch_fault <= 1'b0;
      else      fetch_fault <= accept && misaligned;
   end
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (default ADDR_W=8); honours IMEM_ALIGN_CHK_EN.
module tb_imem_responder;

   localparam int          ADDR_W = 8;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic              clk = 1'b0;
   logic              rst;
   logic              load_en;
   logic [31:0]       load_data;
   logic              load_last;
   logic              load_restart;
   logic              load_done;
   logic [ADDR_W:0]   load_count;
   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_ready;
   logic              fetch_valid;
   logic [31:0]       fetch_instr;
   logic              fetch_fault;

   int checks   = 0;
   int failures = 0;

   logic [31:0] prog [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};

   imem_responder #(.ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_en      (load_en),
      .load_data    (load_data),
      .load_last    (load_last),
      .load_restart (load_restart),
      .load_done    (load_done),
      .load_count   (load_count),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_ready  (fetch_ready),
      .fetch_valid  (fetch_valid),
      .fetch_instr  (fetch_instr),
      .fetch_fault  (fetch_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_done"},  32'(load_done),   32'd0);
      check({tag, "_count"}, 32'(load_count),  32'd0);
      check({tag, "_ready"}, 32'(fetch_ready), 32'd0);
      check({tag, "_valid"}, 32'(fetch_valid), 32'd0);
      check({tag, "_instr"}, fetch_instr,      NOP);
      check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
   endtask

   task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      step();
      check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
      check({tag, "_instr"}, fetch_instr, exp);
      fetch_req = 1'b0;
   endtask

   initial begin
      rst = 1'b0; load_en = 1'b0; load_data = '0; load_last = 1'b0;
      load_restart = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
      #12;
      check_reset_outputs("reset");
      step();
      rst = 1'b1;

      // Fetch in LOAD is ignored; load_last alone does nothing.
      fetch_req = 1'b1; fetch_addr = 32'h0;
      step();
      check("load_fetch_valid", 32'(fetch_valid), 32'd0);
      fetch_req = 1'b0; load_last = 1'b1;
      step();
      check("last_only_count", 32'(load_count), 32'd0);
      check("last_only_done",  32'(load_done),  32'd0);
      load_last = 1'b0;

      for (int i = 0; i < 4; i++) begin
         load_en = 1'b1; load_data = prog[i]; load_last = (i == 3);
         step();
         if (i == 2) check("done_before_last", 32'(load_done), 32'd0);
      end
      load_en = 1'b0; load_last = 1'b0;
      check("load4_done",  32'(load_done),   32'd1);
      check("load4_count", 32'(load_count),  32'd4);
      check("load4_ready", 32'(fetch_ready), 32'd1);

      // Back-to-back fetches with req held high.
      fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         fetch_addr = 32'(i * 4);
         step();
         check($sformatf("b2b%0d_valid", i), 32'(fetch_valid), 32'd1);
         check($sformatf("b2b%0d_instr", i), fetch_instr, prog[i]);
      end
      fetch_req = 1'b0;

      fetch(32'h4, prog[1], "w1");
      step();
      check("hold_valid", 32'(fetch_valid), 32'd0);
      check("hold_instr", fetch_instr, prog[1]);

      fetch(32'h400, NOP, "oor");

      fetch_req = 1'b1; fetch_addr = 32'h6;
      step();
      check("mis_valid", 32'(fetch_valid), 32'd1);
`ifdef IMEM_ALIGN_CHK_EN
      check("mis_instr", fetch_instr, NOP);
      check("mis_fault", 32'(fetch_fault), 32'd1);
`else
      check("mis_instr", fetch_instr, prog[1]);
      check("mis_fault", 32'(fetch_fault), 32'd0);
`endif
      fetch_req = 1'b0;
      step();
      check("mis_fault_clear", 32'(fetch_fault), 32'd0);

      // Restart with a concurrent fetch.
      fetch_req = 1'b1; fetch_addr = 32'h4; load_restart = 1'b1;
      step();
      fetch_req = 1'b0; load_restart = 1'b0;
      check("rs_valid", 32'(fetch_valid), 32'd1);
      check("rs_instr", fetch_instr, prog[1]);
      check("rs_done",  32'(load_done),   32'd0);
      check("rs_ready", 32'(fetch_ready), 32'd0);
      check("rs_count", 32'(load_count),  32'd0);

      load_en = 1'b1; load_data = 32'hDEADBEEF; load_last = 1'b1;
      step();
      load_en = 1'b0; load_last = 1'b0;
      check("reload_done",  32'(load_done),  32'd1);
      check("reload_count", 32'(load_count), 32'd1);
      fetch(32'h0, 32'hDEADBEEF, "reload_w0");
      fetch(32'h4, prog[1],      "reload_w1");

      // Full load without load_last.
      load_restart = 1'b1;
      step();
      load_restart = 1'b0;
      check("full_rs_done", 32'(load_done), 32'd0);
      for (int i = 0; i < 256; i++) begin
         load_en = 1'b1; load_data = 32'h10000000 + 32'(i);
         step();
         if (i == 254) check("full_255_done", 32'(load_done), 32'd0);
      end
      check("full_done",  32'(load_done),  32'd1);
      check("full_count", 32'(load_count), 32'd256);
      load_data = 32'hFFFFFFFF;
      step();
      load_en = 1'b0;
      check("run_load_count", 32'(load_count), 32'd256);
      fetch(32'h0,   32'h10000000, "full_w0");
      fetch(32'h3FC, 32'h100000FF, "full_w255");

      // Async reset in the middle of a fetch stream.
      fetch_req = 1'b1; fetch_addr = 32'h8;
      step();
      check("pre_rst_valid", 32'(fetch_valid), 32'd1);
      rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      #2;
      rst = 1'b1;
      step();
      check("post_rst_valid", 32'(fetch_valid), 32'd0);
      check("post_rst_ready", 32'(fetch_ready), 32'd0);
      fetch_req = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
